// File: rtl/serial_fa_adder.sv
// serial_fa_adder: bit-serial WIDTH-bit adder around a 1-bit full adder (optional ovf via SERIAL_FA_OVF_EN)
module serial_fa_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout,
    output logic             bit_a,
    output logic             bit_b,
    output logic             bit_c
`ifdef SERIAL_FA_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s, maj, last, accept;

    assign s      = a_sr[0] ^ b_sr[0] ^ carry;
    assign maj    = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    assign last   = cnt == CW'(WIDTH - 1);
    assign accept = state == IDLE && start;

    assign busy    = state == RUN;
    assign done    = state == DONE;
    assign sum_out = sum_sr;
    assign cout    = carry;
    assign bit_a   = a_sr[0];
    assign bit_b   = b_sr[0];
    assign bit_c   = carry;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state: IDLE waits for start, RUN lasts WIDTH edges, DONE lasts one cycle
    always_comb begin
        state_nx = state;
        if (accept)                   state_nx = RUN;
        else if (state == RUN && last) state_nx = DONE;
        else if (state == DONE)        state_nx = IDLE;
    end

    // operand load on accepted start, then one full-adder step per RUN edge
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            carry <= cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= (sum_sr >> 1) | (WIDTH'(s) << (WIDTH - 1));
            carry  <= maj;
            cnt    <= cnt + 1'b1;
        end
    end

`ifdef SERIAL_FA_OVF_EN
    // signed overflow: carry into the MSB differs from carry out of it
    always_ff @(posedge clk) begin
        if (rst || accept)             ovf <= 1'b0;
        else if (state == RUN && last) ovf <= carry ^ maj;
    end
`endif
endmodule

// File: tb/tb_serial_fa_adder.sv
// tb_serial_fa_adder: directed and random checks of serial_fa_adder against an arithmetic reference
module tb_serial_fa_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout, bit_a, bit_b, bit_c;
    logic [W-1:0] sum_out;
`ifdef SERIAL_FA_OVF_EN
    logic         ovf;
`endif

    int tests = 0;
    int fails = 0;

    serial_fa_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
        .busy(busy), .done(done), .sum_out(sum_out), .cout(cout),
        .bit_a(bit_a), .bit_b(bit_b), .bit_c(bit_c)
`ifdef SERIAL_FA_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer addition, carry into bit i from the low i bits
    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_carry_in(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int i);
        longint unsigned m = (64'd1 << i) - 1;
        return 1'(((longint'(a) & m) + (longint'(b) & m) + longint'(c)) >> i);
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] r = ref_sum(a, b, c);
        return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    endfunction

    // One addition; inj >= 0 pulses a spurious start with other operands on that RUN cycle
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int inj);
        logic [W:0] r = ref_sum(a, b, c);
        a_in = a; b_in = b; cin = c; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            check("busy_run", busy, 1);
            check("done_run", done, 0);
            check("bit_a", bit_a, a[i]);
            check("bit_b", bit_b, b[i]);
            check("bit_c", bit_c, ref_carry_in(a, b, c, i));
            if (i == inj) begin
                a_in = 8'hAA; b_in = 8'h55; start = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        check("done_pulse", done, 1);
        check("busy_done", busy, 0);
        check("sum", sum_out, r[W-1:0]);
        check("cout", cout, r[W]);
`ifdef SERIAL_FA_OVF_EN
        check("ovf", ovf, ref_ovf(a, b, c));
`endif
        tick();
        check("done_clear", done, 0);
        check("busy_idle", busy, 0);
        check("sum_hold", sum_out, r[W-1:0]);
    endtask

    initial begin
        int d1, d2, nd;
        logic [W:0] r;

        // reset with start held high
        rst = 1'b1; start = 1'b1; a_in = 8'h3C; b_in = 8'h5A;
        tick();
        check("rst_busy", busy, 0);
        tick();
        check("rst_busy2", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum_out, 0);
        check("rst_cout", cout, 0);
        check("rst_bits", {bit_a, bit_b, bit_c}, 0);
`ifdef SERIAL_FA_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        rst = 1'b0; start = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // directed cases
        run_op(8'h3C, 8'h5A, 1'b0, -1);
        run_op(8'hFF, 8'h01, 1'b0, -1);
        run_op(8'hFF, 8'hFF, 1'b1, -1);
        run_op(8'h10, 8'h20, 1'b0, 2);
        tick();
        check("no_queue", busy, 0);

        // abort on RUN cycle 4
        a_in = 8'h3C; b_in = 8'h5A; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("abort_busy_pre", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_sum", sum_out, 0);
        check("abort_cout", cout, 0);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            nd += int'(done);
            tick();
        end
        check("abort_no_done", nd, 0);
        run_op(8'h01, 8'h01, 1'b0, -1);

        // back-to-back with start held high
        a_in = 8'h81; b_in = 8'h92; cin = 1'b1; start = 1'b1;
        r = ref_sum(8'h81, 8'h92, 1'b1);
        d1 = -1; d2 = -1; nd = 0;
        for (int t = 0; t < 40 && nd < 2; t++) begin
            tick();
            if (done) begin
                nd++;
                if (nd == 1) d1 = t; else d2 = t;
                check("b2b_sum", sum_out, r[W-1:0]);
                check("b2b_cout", cout, r[W]);
                if (nd == 2) start = 1'b0;
            end
        end
        check("b2b_count", nd, 2);
        check("b2b_gap", d2 - d1, W + 2);
        tick(); tick();
        check("b2b_idle", busy, 0);

        // random operands
        for (int k = 0; k < 20; k++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
